accelerator_fsm: RTL and testbench
==================================

ACCELERATOR_FSM -- requirements
Module: accelerator_fsm

Interface
REQ-001 SHALL have parameter WIDTH_LBIT_CNT, default 6: low (element) counter width; 2^WIDTH_LBIT_CNT operands per row.
REQ-002 SHALL have parameter WIDTH_HBIT_CNT, default 3: high (row) counter width; 2^WIDTH_HBIT_CNT rows per job.
REQ-003 SHALL have the port list below; one clock; reset is synchronous and active-low.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset.
- data_rdy_i  in  1  operand source has data available.
- LCNT_en_o  out  1  low counter increment enable.
- LCNT_rst_o  out  1  low counter synchronous clear, active-high.
- LCNT_data_i  in  WIDTH_LBIT_CNT  low counter value.
- HCNT_en_o  out  1  high counter increment enable.
- HCNT_rst_o  out  1  high counter synchronous clear, active-high.
- HCNT_data_i  in  WIDTH_HBIT_CNT  high counter value; wider drivers are truncated to the low WIDTH_HBIT_CNT bits.
- read_en_o  out  1  operand read strobe, one operand per asserted cycle.
- wire_connect_o  out  2  datapath mux select: 00 idle, 01 multiply-accumulate, 10 writeback, 11 done.

Function
REQ-004 SHALL be a 4-state machine (IDLE, MAC, WB, DONE): state registered, outputs combinational from state plus counter inputs.
REQ-005 IDLE: wire_connect_o=00, LCNT_rst_o=1, HCNT_rst_o=1, all else 0; go to MAC when data_rdy_i=1.
REQ-006 MAC, data_rdy_i=1: read_en_o=1, LCNT_en_o=1, wire_connect_o=01.
REQ-007 MAC exit: when LCNT_data_i = 2^WIDTH_LBIT_CNT-1 and read_en_o=1, go to WB next cycle; otherwise stay in MAC.
REQ-008 WB: one cycle only; wire_connect_o=10, HCNT_en_o=1, LCNT_rst_o=1, read_en_o=0.
REQ-009 WB exit: if HCNT_data_i = 2^WIDTH_HBIT_CNT-1, go to DONE; else go to MAC.
REQ-010 DONE: wire_connect_o=11, LCNT_rst_o=1, HCNT_rst_o=1; stay while data_rdy_i=1; go to IDLE when data_rdy_i=0 (no retrigger on held ready).
REQ-011 Per job: exactly 2^WIDTH_LBIT_CNT read_en_o pulses per row, 2^WIDTH_HBIT_CNT WB cycles; defaults give 512 reads and 520 active cycles with no stall.
REQ-012 LCNT_en_o and LCNT_rst_o SHALL never both be 1; the same holds for HCNT_en_o and HCNT_rst_o.
REQ-013 Unreachable state encodings SHALL return to IDLE on the next clock.

Reset
REQ-014 While rst_n=0 at a rising edge: state <= IDLE.
REQ-015 While rst_n=0 the outputs SHALL be LCNT_rst_o=1 and HCNT_rst_o=1, with all other outputs 0 and wire_connect_o=00.
REQ-016 Reset asserted in any state, including mid-MAC, SHALL abort the job without a WB cycle; counters are cleared through the rst outputs.

Configuration
REQ-017 SHALL have macro ACCEL_FSM_STALL_EN to control MAC-state stalling on data_rdy_i=0.
REQ-018 With ACCEL_FSM_STALL_EN defined, MAC with data_rdy_i=0: read_en_o=0 and LCNT_en_o=0 (counter holds); state holds.
REQ-019 Without ACCEL_FSM_STALL_EN, MAC ignores data_rdy_i and reads every cycle.

Structure
REQ-020 Package accelerator_pkg SHALL hold the state enum typedef and the four wire_connect_o encodings as named constants.
REQ-021 Sub-module counter, parameter WIDTH_CNT, ports clk, cnt_rst_i, cnt_en_i, cnt_o[WIDTH_CNT-1:0].
REQ-022 counter function: synchronous clear has priority over enable; increments by 1 when enabled; wraps from max to 0; has no other reset.
REQ-023 The system level instantiates two counters: the L counter (WIDTH_LBIT_CNT) and the H counter (WIDTH_HBIT_CNT).

Verification
REQ-024 Reset case: rst_n=0 for 10 cycles -> wire_connect_o=00, LCNT_rst_o=HCNT_rst_o=1, counters read 0.
REQ-025 Full job case: after reset, data_rdy_i=1 held -> 512 read_en_o pulses and 8 WB cycles with wire_connect_o=10, then DONE (11) held while ready stays 1.
REQ-026 Row boundary case: LCNT=63 in MAC -> next cycle WB, LCNT returns to 0, and HCNT increments by 1.
REQ-027 Stall case (STALL_EN on): data_rdy_i=0 for 5 cycles mid-MAC at LCNT=20 -> read_en_o=0 and LCNT stays 20; reads resume when ready returns; total still 512.
REQ-028 Mid-job reset case: rst_n=0 during row 3 -> IDLE next cycle, both counters cleared, no WB.
REQ-029 Restart case: in DONE, drop data_rdy_i -> IDLE; reassert it -> a new job starts with LCNT=HCNT=0.

Source files
------------

// File: rtl/accelerator_pkg.sv
// Shared types for the accelerator sequencer: state encoding and datapath mux selects.
// wire_connect_o values equal the state encodings, so the mux select also shows the state.
package accelerator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MAC  = 2'b01,
        ST_WB   = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam logic [1:0] WC_IDLE = 2'b00;
    localparam logic [1:0] WC_MAC  = 2'b01;
    localparam logic [1:0] WC_WB   = 2'b10;
    localparam logic [1:0] WC_DONE = 2'b11;

endpackage

// File: rtl/counter.sv
// Wrapping up-counter with synchronous clear. Clear wins over enable.
// It has no reset of its own; the sequencer clears it through cnt_rst_i.
module counter #(
    parameter int WIDTH_CNT = 6
) (
    input  logic                 clk,
    input  logic                 cnt_rst_i,
    input  logic                 cnt_en_i,
    output logic [WIDTH_CNT-1:0] cnt_o
);

    always_ff @(posedge clk) begin
        if (cnt_rst_i) begin
            cnt_o <= '0;
        end else if (cnt_en_i) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

endmodule

// File: rtl/accelerator_fsm.sv
// Row/element sequencer for a multiply-accumulate job: IDLE -> MAC -> WB (per row) -> DONE.
// Define ACCEL_FSM_STALL_EN to let MAC pause reads while data_rdy_i is low.
module accelerator_fsm
    import accelerator_pkg::*;
#(
    parameter int WIDTH_LBIT_CNT = 6,
    parameter int WIDTH_HBIT_CNT = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      data_rdy_i,
    output logic                      LCNT_en_o,
    output logic                      LCNT_rst_o,
    input  logic [WIDTH_LBIT_CNT-1:0] LCNT_data_i,
    output logic                      HCNT_en_o,
    output logic                      HCNT_rst_o,
    input  logic [WIDTH_HBIT_CNT-1:0] HCNT_data_i,
    output logic                      read_en_o,
    output logic [1:0]                wire_connect_o
);

    localparam logic [WIDTH_LBIT_CNT-1:0] L_LAST = '1;
    localparam logic [WIDTH_HBIT_CNT-1:0] H_LAST = '1;

    state_t state;
    state_t next_state;
    logic   rd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state     = state;
        rd             = 1'b0;
        LCNT_en_o      = 1'b0;
        LCNT_rst_o     = 1'b0;
        HCNT_en_o      = 1'b0;
        HCNT_rst_o     = 1'b0;
        read_en_o      = 1'b0;
        wire_connect_o = WC_IDLE;

        case (state)
            ST_IDLE: begin
                LCNT_rst_o = 1'b1;
                HCNT_rst_o = 1'b1;
                if (data_rdy_i) begin
                    next_state = ST_MAC;
                end
            end
            ST_MAC: begin
                wire_connect_o = WC_MAC;
`ifdef ACCEL_FSM_STALL_EN
                rd = data_rdy_i;
`else
                rd = 1'b1;
`endif
                read_en_o = rd;
                LCNT_en_o = rd;
                // Leave only once the last element of the row has actually been read.
                if (rd && (LCNT_data_i == L_LAST)) begin
                    next_state = ST_WB;
                end
            end
            ST_WB: begin
                wire_connect_o = WC_WB;
                HCNT_en_o      = 1'b1;
                LCNT_rst_o     = 1'b1;
                next_state     = (HCNT_data_i == H_LAST) ? ST_DONE : ST_MAC;
            end
            ST_DONE: begin
                wire_connect_o = WC_DONE;
                LCNT_rst_o     = 1'b1;
                HCNT_rst_o     = 1'b1;
                // A held ready must not retrigger; wait for it to drop first.
                if (!data_rdy_i) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

        // Reset overrides everything so counters clear and no read/writeback leaks out.
        if (!rst_n) begin
            next_state     = ST_IDLE;
            LCNT_en_o      = 1'b0;
            HCNT_en_o      = 1'b0;
            read_en_o      = 1'b0;
            LCNT_rst_o     = 1'b1;
            HCNT_rst_o     = 1'b1;
            wire_connect_o = WC_IDLE;
        end
    end

endmodule

// File: tb/tb_accelerator_fsm.sv
// Directed bench for accelerator_fsm wired to its two counters (default widths 6/3).
module tb_accelerator_fsm;

    localparam int WL = 6;
    localparam int WH = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          data_rdy;
    logic          lcnt_en, lcnt_rst, hcnt_en, hcnt_rst, read_en;
    logic [1:0]    wc;
    logic [WL-1:0] lcnt;
    logic [WH-1:0] hcnt;

    int checks   = 0;
    int failures = 0;
    logic [WH-1:0] exp_q[$];

    always #5 clk = ~clk;

    accelerator_fsm #(.WIDTH_LBIT_CNT(WL), .WIDTH_HBIT_CNT(WH)) dut (
        .clk(clk), .rst_n(rst_n), .data_rdy_i(data_rdy),
        .LCNT_en_o(lcnt_en), .LCNT_rst_o(lcnt_rst), .LCNT_data_i(lcnt),
        .HCNT_en_o(hcnt_en), .HCNT_rst_o(hcnt_rst), .HCNT_data_i(hcnt),
        .read_en_o(read_en), .wire_connect_o(wc)
    );

    counter #(.WIDTH_CNT(WL)) u_lcnt (.clk(clk), .cnt_rst_i(lcnt_rst), .cnt_en_i(lcnt_en), .cnt_o(lcnt));
    counter #(.WIDTH_CNT(WH)) u_hcnt (.clk(clk), .cnt_rst_i(hcnt_rst), .cnt_en_i(hcnt_en), .cnt_o(hcnt));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        data_rdy = 1'b1;
        repeat (10) tick;
        checks++; if (wc !== 2'b00) begin failures++; $display("FAIL reset_wc got=%b exp=00", wc); end
        checks++; if (lcnt_rst !== 1'b1 || hcnt_rst !== 1'b1) begin failures++; $display("FAIL reset_rst got=%b%b exp=11", lcnt_rst, hcnt_rst); end
        checks++; if ({read_en, lcnt_en, hcnt_en} !== 3'b000) begin failures++; $display("FAIL reset_en got=%b exp=000", {read_en, lcnt_en, hcnt_en}); end
        checks++; if (lcnt !== '0 || hcnt !== '0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", lcnt, hcnt); end
        data_rdy = 1'b0;
        rst_n    = 1'b1;
        tick;
        checks++; if (wc !== 2'b00) begin failures++; $display("FAIL idle_hold got=%b exp=00", wc); end
    endtask

    task automatic test_full_job;
        int reads = 0, wbs = 0, active = 0, excl = 0;
        bit done = 0;
        logic [WH-1:0] exp_h;
        exp_q.delete();
        for (int r = 0; r < 8; r++) exp_q.push_back(WH'(r));
        data_rdy = 1'b1;
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            tick;
            if ((lcnt_en && lcnt_rst) || (hcnt_en && hcnt_rst)) excl++;
            if (read_en) reads++;
            if (wc == 2'b01 || wc == 2'b10) active++;
            if (wc == 2'b10) begin
                wbs++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL wb_extra got=%0d exp=none", hcnt);
                end else begin
                    exp_h = exp_q.pop_front();
                    if (hcnt !== exp_h) begin failures++; $display("FAIL wb_row got=%0d exp=%0d", hcnt, exp_h); end
                end
            end
            if (wc == 2'b11) done = 1;
        end
        checks++; if (!done) begin failures++; $display("FAIL job_done got=0 exp=1"); end
        checks++; if (reads != 512) begin failures++; $display("FAIL job_reads got=%0d exp=512", reads); end
        checks++; if (wbs != 8) begin failures++; $display("FAIL job_wbs got=%0d exp=8", wbs); end
        checks++; if (active != 520) begin failures++; $display("FAIL job_active got=%0d exp=520", active); end
        checks++; if (excl != 0) begin failures++; $display("FAIL en_rst_excl got=%0d exp=0", excl); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL wb_missing got=%0d exp=0", exp_q.size()); end
        repeat (3) begin
            tick;
            checks++; if (wc !== 2'b11) begin failures++; $display("FAIL done_hold got=%b exp=11", wc); end
        end
        checks++; if (lcnt !== '0 || hcnt !== '0) begin failures++; $display("FAIL done_cnt got=%0d/%0d exp=0/0", lcnt, hcnt); end
    endtask

    task automatic test_restart;
        data_rdy = 1'b0;
        tick;
        checks++; if (wc !== 2'b00) begin failures++; $display("FAIL restart_idle got=%b exp=00", wc); end
        data_rdy = 1'b1;
        tick;
        checks++; if (wc !== 2'b01 || read_en !== 1'b1) begin failures++; $display("FAIL restart_mac got=%b/%b exp=01/1", wc, read_en); end
        checks++; if (lcnt !== '0 || hcnt !== '0) begin failures++; $display("FAIL restart_cnt got=%0d/%0d exp=0/0", lcnt, hcnt); end
    endtask

    task automatic test_row_boundary;
        logic [WH-1:0] h, h1;
        for (int i = 0; i < 100 && lcnt != 6'd63; i++) tick;
        checks++; if (lcnt !== 6'd63 || wc !== 2'b01 || read_en !== 1'b1) begin
            failures++; $display("FAIL row_last got=%0d/%b/%b exp=63/01/1", lcnt, wc, read_en);
        end
        h  = hcnt;
        h1 = h + 1'b1;
        tick;
        checks++; if (wc !== 2'b10 || lcnt !== '0 || hcnt !== h) begin
            failures++; $display("FAIL row_wb got=%b/%0d/%0d exp=10/0/%0d", wc, lcnt, hcnt, h);
        end
        checks++; if (hcnt_en !== 1'b1 || read_en !== 1'b0 || lcnt_rst !== 1'b1) begin
            failures++; $display("FAIL row_wb_out got=%b%b%b exp=101", hcnt_en, read_en, lcnt_rst);
        end
        tick;
        checks++; if (wc !== 2'b01 || lcnt !== '0 || hcnt !== h1) begin
            failures++; $display("FAIL row_next got=%b/%0d/%0d exp=01/0/%0d", wc, lcnt, hcnt, h1);
        end
    endtask

    task automatic test_stall;
        int reads = 0, bad = 0;
        bit done = 0, stalled = 0;
        rst_n = 1'b0;
        tick;
        rst_n    = 1'b1;
        data_rdy = 1'b1;
        for (int cyc = 0; cyc < 700 && !done; cyc++) begin
            tick;
            if (!stalled && wc == 2'b01 && lcnt == 6'd20 && hcnt == '0) begin
                stalled  = 1;
                data_rdy = 1'b0;
                settle;
                for (int s = 0; s < 5; s++) begin
                    if (read_en) reads++;
`ifdef ACCEL_FSM_STALL_EN
                    if (read_en !== 1'b0 || lcnt_en !== 1'b0 || int'(lcnt) != 20 || wc !== 2'b01) bad++;
`else
                    if (read_en !== 1'b1 || int'(lcnt) != 20 + s || wc !== 2'b01) bad++;
`endif
                    tick;
                end
                checks++; if (bad != 0) begin failures++; $display("FAIL stall_window got=%0d exp=0", bad); end
                data_rdy = 1'b1;
                settle;
`ifdef ACCEL_FSM_STALL_EN
                checks++; if (read_en !== 1'b1 || int'(lcnt) != 20) begin failures++; $display("FAIL stall_resume got=%b/%0d exp=1/20", read_en, lcnt); end
`else
                checks++; if (read_en !== 1'b1 || int'(lcnt) != 25) begin failures++; $display("FAIL stall_resume got=%b/%0d exp=1/25", read_en, lcnt); end
`endif
            end
            if (read_en) reads++;
            if (wc == 2'b11) done = 1;
        end
        checks++; if (!stalled || !done) begin failures++; $display("FAIL stall_job got=%0d%0d exp=11", stalled, done); end
        checks++; if (reads != 512) begin failures++; $display("FAIL stall_reads got=%0d exp=512", reads); end
    endtask

    task automatic test_mid_reset;
        int wb_seen = 0;
        data_rdy = 1'b0;
        tick;
        data_rdy = 1'b1;
        for (int i = 0; i < 400 && !(hcnt == 3'd3 && lcnt == 6'd10 && wc == 2'b01); i++) tick;
        checks++; if (hcnt !== 3'd3 || lcnt !== 6'd10) begin failures++; $display("FAIL mid_reach got=%0d/%0d exp=3/10", hcnt, lcnt); end
        rst_n = 1'b0;
        settle;
        checks++; if ({wc, read_en, lcnt_en, hcnt_en, lcnt_rst, hcnt_rst} !== 7'b00_000_11) begin
            failures++; $display("FAIL mid_rst_out got=%b exp=0000011", {wc, read_en, lcnt_en, hcnt_en, lcnt_rst, hcnt_rst});
        end
        tick;
        checks++; if (wc !== 2'b00 || lcnt !== '0 || hcnt !== '0) begin
            failures++; $display("FAIL mid_rst_idle got=%b/%0d/%0d exp=00/0/0", wc, lcnt, hcnt);
        end
        repeat (3) begin
            tick;
            if (wc == 2'b10 || hcnt_en) wb_seen++;
        end
        rst_n    = 1'b1;
        data_rdy = 1'b0;
        tick;
        if (wc == 2'b10) wb_seen++;
        checks++; if (wb_seen != 0) begin failures++; $display("FAIL mid_rst_nowb got=%0d exp=0", wb_seen); end
        checks++; if (wc !== 2'b00) begin failures++; $display("FAIL mid_rst_after got=%b exp=00", wc); end
    endtask

    initial begin
        test_reset;
        test_full_job;
        test_restart;
        test_row_boundary;
        test_stall;
        test_mid_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
